// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package div_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    // Widest operand the MIN helper can describe
    localparam int MAX_WIDTH = 64;

    // Every quotient bit is set when the divisor is zero
    localparam logic DBZ_QUOT_FILL = 1'b1;

    // Most negative two's-complement value of the given width (1 followed by zeros)
    function automatic logic [MAX_WIDTH-1:0] min_const(input int width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/div_negate.sv
// Two's-complement negate of a WIDTH-bit value.
// Latency: purely combinational, zero cycles.
// Backpressure: none, output follows input continuously.
module div_negate
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = ~din + WIDTH'(1);

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned restoring divider returning quotient and remainder.
// Latency: WIDTH+2 cycles from start for normal ops; done in the cycle after start for /0 and MIN/-1.
// Backpressure: start is only taken while ready=1; starts while busy are dropped, not queued.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32,              // 4..MAX_WIDTH
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MIN_VAL  = WIDTH'(min_const(WIDTH));
    localparam logic [WIDTH-1:0] DBZ_QUOT = {WIDTH{DBZ_QUOT_FILL}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dv_mag;   // divisor magnitude
    logic [WIDTH-1:0] rem_p;    // partial remainder
    logic [WIDTH-1:0] quo_p;    // dividend magnitude shifting out, quotient bits shifting in
    logic             q_neg;
    logic             r_neg;

    logic [WIDTH-1:0] dd_neg, dv_neg, dd_abs, dv_abs;
    logic [WIDTH-1:0] q_fix_neg, r_fix_neg;
    logic [WIDTH:0]   shifted;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;

    // Operand magnitudes, taken straight from the inputs at the start edge
    div_negate #(.WIDTH(WIDTH)) u_neg_dd (.din(dividend), .dout(dd_neg));
    div_negate #(.WIDTH(WIDTH)) u_neg_dv (.din(divisor),  .dout(dv_neg));

    assign dd_abs = (is_signed && dividend[WIDTH-1]) ? dd_neg : dividend;
    assign dv_abs = (is_signed && divisor[WIDTH-1])  ? dv_neg : divisor;

    // Sign restoration applied in FIX
    div_negate #(.WIDTH(WIDTH)) u_neg_q (.din(quo_p), .dout(q_fix_neg));
    div_negate #(.WIDTH(WIDTH)) u_neg_r (.din(rem_p), .dout(r_fix_neg));

    // One restoring step: the shifted remainder is WIDTH+1 bits wide so a divisor
    // with its MSB set (unsigned mode) still compares correctly. When the trial
    // subtract succeeds the result is below the divisor and fits in WIDTH bits.
    assign shifted = {rem_p, quo_p[WIDTH-1]};
    assign q_bit   = (shifted >= {1'b0, dv_mag});
    assign rem_nxt = q_bit ? (shifted[WIDTH-1:0] - dv_mag) : shifted[WIDTH-1:0];

    // Control FSM, datapath registers and registered results
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ready       <= 1'b1;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            dv_mag      <= '0;
            rem_p       <= '0;
            quo_p       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ready  <= 1'b0;
                        q_neg  <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg  <= is_signed & dividend[WIDTH-1];
                        dv_mag <= dv_abs;
                        quo_p  <= dd_abs;
                        rem_p  <= '0;
                        cnt    <= '0;
                        if (divisor == '0) begin
                            // Zero divisor wins over the overflow case
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= DBZ_QUOT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else if (is_signed && dividend == MIN_VAL && divisor == '1) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= MIN_VAL;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_p <= rem_nxt;
                    quo_p <= {quo_p[WIDTH-2:0], q_bit};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Truncating division: remainder carries the dividend's sign
                    quotient    <= q_neg ? q_fix_neg : quo_p;
                    remainder   <= r_neg ? r_fix_neg : rem_p;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: WIDTH=32 and WIDTH=8 instances against an arithmetic model.
// Latency: completion cycle of every op is checked against the expected due cycle.
// Backpressure: starts while busy must be dropped; checked through result and timing.
module tb_div_seq;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, is_signed;
    logic [31:0] dividend, divisor;
    logic        ready, done, div_by_zero, overflow;
    logic [31:0] quotient, remainder;

    logic        start8, sgn8;
    logic [7:0]  dd8, dv8;
    logic        ready8, done8, dbz8, ovf8;
    logic [7:0]  quo8, rem8;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb32[$];
    exp_t sb8[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    div_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .ready(ready), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    div_seq #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .is_signed(sgn8),
        .dividend(dd8), .divisor(dv8), .ready(ready8), .done(done8),
        .quotient(quo8), .remainder(rem8),
        .div_by_zero(dbz8), .overflow(ovf8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout(input string name);
        checks++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Reference: plain integer division on 64-bit values, truncating toward zero
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input int w, input logic sgn);
        exp_t        e;
        logic [63:0] mask, minv, ua, ub;
        longint      sa, sd;
        mask  = (64'd1 << w) - 64'd1;
        minv  = 64'd1 << (w - 1);
        ua    = {32'b0, a} & mask;
        ub    = {32'b0, b} & mask;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.due = 0;
        if (ub == 64'd0) begin
            e.q = 32'(mask); e.r = 32'(ua); e.dbz = 1'b1;
        end else if (sgn && ua == minv && ub == mask) begin
            e.q = 32'(minv); e.r = 32'd0; e.ovf = 1'b1;
        end else if (sgn) begin
            sa = longint'(ua);
            sd = longint'(ub);
            if (ua[w-1]) sa = sa - longint'(64'd1 << w);
            if (ub[w-1]) sd = sd - longint'(64'd1 << w);
            e.q = 32'(64'(sa / sd) & mask);
            e.r = 32'(64'(sa % sd) & mask);
        end else begin
            e.q = 32'(ua / ub);
            e.r = 32'(ua % ub);
        end
        return e;
    endfunction

    // Call at the start edge + #1: queues the expected result with its due cycle
    task automatic push32(input logic sg, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e     = model(a, b, 32, sg);
        e.due = cyc + ((e.dbz || e.ovf) ? 0 : 33);
        sb32.push_back(e);
    endtask

    task automatic issue32(input logic sg, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clock);
        while (!ready && n < 200) begin @(negedge clock); n++; end
        if (!ready) timeout("ready32");
        is_signed = sg; dividend = a; divisor = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        push32(sg, a, b);
        chk("ready_low_after_start", {31'b0, ready}, 32'd0);
        dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic issue8(input logic sg, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   n = 0;
        @(negedge clock);
        while (!ready8 && n < 200) begin @(negedge clock); n++; end
        if (!ready8) timeout("ready8");
        sgn8 = sg; dd8 = a; dv8 = b; start8 = 1'b1;
        @(posedge clock); #1;
        start8 = 1'b0;
        e     = model({24'b0, a}, {24'b0, b}, 8, sg);
        e.due = cyc + ((e.dbz || e.ovf) ? 0 : 9);
        sb8.push_back(e);
        dd8 = 8'($urandom); dv8 = 8'($urandom);
    endtask

    task automatic wait_done32();
        int n = 0;
        @(negedge clock);
        while (!done && n < 100) begin @(negedge clock); n++; end
        if (!done) timeout("done32");
    endtask

    // Monitor for the 32-bit instance: compares results, timing, busy and hold
    always @(negedge clock) begin : mon32
        exp_t e;
        exp_t last;
        bit   hold;
        if (hold) begin
            chk("hold_quotient32", quotient, last.q);
            chk("hold_remainder32", remainder, last.r);
            hold = 1'b0;
        end
        if (done) begin
            if (sb32.size() == 0) begin
                checks++;
                $display("FAIL spurious_done32: done=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                e = sb32.pop_front();
                chk("quotient32", quotient, e.q);
                chk("remainder32", remainder, e.r);
                chk("div_by_zero32", {31'b0, div_by_zero}, {31'b0, e.dbz});
                chk("overflow32", {31'b0, overflow}, {31'b0, e.ovf});
                chk("done_cycle32", cyc, e.due);
                last = e;
                hold = 1'b1;
            end
        end else if (sb32.size() != 0) begin
            chk("ready_busy32", {31'b0, ready}, 32'd0);
        end
    end

    // Monitor for the 8-bit instance
    always @(negedge clock) begin : mon8
        exp_t e;
        if (done8) begin
            if (sb8.size() == 0) begin
                checks++;
                $display("FAIL spurious_done8: done=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                e = sb8.pop_front();
                chk("quotient8", {24'b0, quo8}, e.q);
                chk("remainder8", {24'b0, rem8}, e.r);
                chk("div_by_zero8", {31'b0, dbz8}, {31'b0, e.dbz});
                chk("overflow8", {31'b0, ovf8}, {31'b0, e.ovf});
                chk("done_cycle8", cyc, e.due);
            end
        end else if (sb8.size() != 0) begin
            chk("ready_busy8", {31'b0, ready8}, 32'd0);
        end
    end

    initial begin
        logic [31:0] a, b;
        int          n;
        reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        start8 = 1'b0; sgn8 = 1'b0; dd8 = '0; dv8 = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_ready", {31'b0, ready}, 32'd1);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        chk("reset_flags", {30'b0, div_by_zero, overflow}, 32'd0);
        chk("reset_ready8", {31'b0, ready8}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed cases
        issue32(1'b0, 32'd100, 32'd7);
        issue32(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        issue32(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
        issue32(1'b0, 32'd5, 32'd0);
        issue32(1'b1, 32'd5, 32'd0);
        issue32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        issue32(1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
        issue32(1'b1, 32'h8000_0000, 32'h0000_0000);

        // Start pulsed mid-calculation must be ignored
        issue32(1'b0, 32'd123456, 32'd17);
        repeat (5) @(negedge clock);
        start = 1'b1; dividend = 32'd999; divisor = 32'd1; is_signed = 1'b0;
        @(negedge clock);
        start = 1'b0;

        // Start held through the DONE cycle: taken only on the following IDLE cycle
        wait_done32();
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        @(posedge clock);
        @(posedge clock); #1;
        start = 1'b0;
        push32(1'b0, 32'd1000, 32'd10);

        // Reset in the middle of an operation
        issue32(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        sb32.delete();
        @(posedge clock); #1;
        chk("midreset_ready", {31'b0, ready}, 32'd1);
        chk("midreset_done", {31'b0, done}, 32'd0);
        chk("midreset_quotient", quotient, 32'd0);
        chk("midreset_remainder", remainder, 32'd0);
        chk("midreset_flags", {30'b0, div_by_zero, overflow}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        issue32(1'b1, 32'hFFFF_FF9C, 32'd7);

        // Randomized ops with a bias toward the special cases
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = $urandom_range(1, 15);
                1: b = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            issue32(1'($urandom_range(0, 1)), a, b);
        end

        // Narrow instance
        issue8(1'b0, 8'd200, 8'd3);
        issue8(1'b1, 8'h80, 8'hFF);
        issue8(1'b0, 8'h80, 8'hFF);
        issue8(1'b1, 8'h2A, 8'h00);
        for (int i = 0; i < 20; i++) begin
            issue8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 255)));
        end

        n = 0;
        while ((sb32.size() != 0 || sb8.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb32.size() != 0 || sb8.size() != 0) timeout("drain");
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
